mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the two-port line-memory arbiter.
// The arbiter takes the slave modport; the cache/memory environment takes master.
interface mem_arbiter_if #(
    parameter int AW = 28,
    parameter int DW = 128
);
    logic          Req_0;
    logic          Wr_0;
    logic [AW-1:0] A_0;
    logic [DW-1:0] DO_0;
    logic          Req_1;
    logic          Wr_1;
    logic [AW-1:0] A_1;
    logic [DW-1:0] DO_1;
    logic          Rdy_0;
    logic          Rdy_1;
    logic          Err;
    logic [DW-1:0] DI_Out;
    logic          Req_Low;
    logic          Wr_Low;
    logic [AW-1:0] A_Low;
    logic [DW-1:0] DO_Low;
    logic          Rdy_Low;
    logic [DW-1:0] DI_Low;
    logic [1:0]    Grant;
    logic          Busy;

    modport slave (
        input  Req_0, Wr_0, A_0, DO_0,
        input  Req_1, Wr_1, A_1, DO_1,
        input  Rdy_Low, DI_Low,
        output Rdy_0, Rdy_1, Err, DI_Out,
        output Req_Low, Wr_Low, A_Low, DO_Low,
        output Grant, Busy
    );

    modport master (
        output Req_0, Wr_0, A_0, DO_0,
        output Req_1, Wr_1, A_1, DO_1,
        output Rdy_Low, DI_Low,
        input  Rdy_0, Rdy_1, Err, DI_Out,
        input  Req_Low, Wr_Low, A_Low, DO_Low,
        input  Grant, Busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single line memory, with
// alternating tie-break, latched request fields and a BUSY timeout.
module mem_arbiter #(
    parameter int Width_of_A_Low    = 28,
    parameter int Memory_Block_Size = 128,
    parameter int TO_W              = 8
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              last;
    logic [TO_W-1:0]   cnt;

    logic                         pick_1;
    logic                         wr_sel;
    logic [Width_of_A_Low-1:0]    a_sel;
    logic [Memory_Block_Size-1:0] d_sel;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign pick_1 = bus.Req_1 && !(bus.Req_0 && last);
    assign wr_sel = pick_1 ? bus.Wr_1 : bus.Wr_0;
    assign a_sel  = pick_1 ? bus.A_1  : bus.A_0;
    assign d_sel  = pick_1 ? bus.DO_1 : bus.DO_0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= '0;
            bus.Req_Low <= 1'b0;
            bus.Wr_Low  <= 1'b0;
            bus.A_Low   <= '0;
            bus.DO_Low  <= '0;
            bus.DI_Out  <= '0;
            bus.Rdy_0   <= 1'b0;
            bus.Rdy_1   <= 1'b0;
            bus.Err     <= 1'b0;
            bus.Grant   <= 2'b00;
            bus.Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req_0 || bus.Req_1) begin
                        state       <= BUSY;
                        bus.Grant   <= pick_1 ? 2'b10 : 2'b01;
                        bus.Req_Low <= 1'b1;
                        bus.Wr_Low  <= wr_sel;
                        bus.A_Low   <= a_sel;
                        bus.DO_Low  <= d_sel;
                        bus.Busy    <= 1'b1;
                        cnt         <= '0;
                    end
                end
                BUSY: begin
                    if (bus.Rdy_Low) begin
                        state       <= DONE;
                        bus.Req_Low <= 1'b0;
                        bus.Wr_Low  <= 1'b0;
                        bus.Rdy_0   <= bus.Grant[0];
                        bus.Rdy_1   <= bus.Grant[1];
                        bus.Err     <= 1'b0;
                        if (!bus.Wr_Low) begin
                            bus.DI_Out <= bus.DI_Low;
                        end
                    end else if (&cnt) begin
                        // Memory never answered: complete with Err, keep old read data.
                        state       <= DONE;
                        bus.Req_Low <= 1'b0;
                        bus.Wr_Low  <= 1'b0;
                        bus.Rdy_0   <= bus.Grant[0];
                        bus.Rdy_1   <= bus.Grant[1];
                        bus.Err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    last      <= bus.Grant[1];
                    bus.Rdy_0 <= 1'b0;
                    bus.Rdy_1 <= 1'b0;
                    bus.Err   <= 1'b0;
                    bus.Grant <= 2'b00;
                    bus.Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
